// File: rtl/ldst_unit.sv
// ldst_unit: load/store unit with req/ack memory handshake and register write-back.
// Optional LDST_TIMEOUT_EN adds an ack timeout with a sticky err flag.
module ldst_unit #(
  parameter int W = 8,
  parameter int A = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         CLK,
  input  logic         reset_n,
  input  logic         start,
  input  logic         is_store,
  input  logic [W-1:0] addr,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         wb_en,
  output logic [W-1:0] wb_data,
  output logic         mem_req,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  state_e       state_q;
  logic         ld_q;
  logic [A-1:0] addr_q;
  logic [W-1:0] wdata_q;
  logic [W-1:0] rdata_q;
  logic         expire;
`ifdef LDST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign expire = cnt_q == CW'(TIMEOUT - 1);
  assign err    = err_q;
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == REQ) ? cnt_q + 1'b1 : '0;
      err_q <= err_q | (state_q == REQ && !mem_ack && expire);
    end
  end
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ld_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= REQ;
          ld_q    <= !is_store;
          addr_q  <= A'(addr);
          wdata_q <= wdata;
        end
        REQ: if (mem_ack) begin
          state_q <= DONE;
          if (ld_q) rdata_q <= mem_rdata;
        end else if (expire) begin
          // a timed-out load completes without write-back
          state_q <= DONE;
          ld_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy      = state_q != IDLE;
  assign mem_req   = state_q == REQ;
  assign mem_we    = mem_req && !ld_q;
  assign done      = state_q == DONE;
  assign wb_en     = done && ld_q;
  assign wb_data   = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_ldst_unit.sv
// tb_ldst_unit: randomized self-checking bench for ldst_unit with a byte-array memory model.
module tb_ldst_unit;
  logic       CLK, reset_n, start, is_store, mem_ack;
  logic [7:0] addr, wdata, mem_rdata;
  logic       busy, done, wb_en, mem_req, mem_we, err;
  logic [7:0] wb_data, mem_addr, mem_wdata;
  logic [7:0] mem [256];
  logic [7:0] exp_wb;
  int errors = 0;
  int checks = 0;

  ldst_unit #(.W(8), .A(8), .TIMEOUT(4)) dut (
    .CLK(CLK), .reset_n(reset_n), .start(start), .is_store(is_store),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .wb_en(wb_en),
    .wb_data(wb_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Called at a negedge with the unit idle; returns at the negedge of the idle cycle after done.
  task automatic run_op(input logic st, input logic [7:0] a, input logic [7:0] wd, input int waits);
    start = 1'b1; is_store = st; addr = a; wdata = wd;
    @(negedge CLK);
    start = 1'b0; is_store = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if ({mem_req, mem_we, busy, done, mem_addr} !== {1'b1, st, 1'b1, 1'b0, a}) begin
        errors++;
        $display("FAIL req_phase wait %0d: got req/we/busy/done/addr=%b%b%b%b/%h expected 1%b10/%h",
                 i, mem_req, mem_we, busy, done, mem_addr, st, a);
      end
      if (st) begin
        checks++;
        if (mem_wdata !== wd) begin
          errors++;
          $display("FAIL store_wdata wait %0d: got %h expected %h", i, mem_wdata, wd);
        end
      end
      mem_ack = (i == waits);
      mem_rdata = (i == waits) ? mem[a] : 8'($urandom);
      @(negedge CLK);
    end
    if (st) mem[a] = wd;
    else exp_wb = mem[a];
    checks++;
    if ({done, wb_en, busy, mem_req, wb_data} !== {1'b1, !st, 1'b1, 1'b0, exp_wb}) begin
      errors++;
      $display("FAIL done_phase: got done/wb_en/busy/req/wb_data=%b%b%b%b/%h expected 1%b10/%h",
               done, wb_en, busy, mem_req, wb_data, !st, exp_wb);
    end
    mem_ack = 1'($urandom); mem_rdata = 8'($urandom);
    @(negedge CLK);
    mem_ack = 1'($urandom);
    checks++;
    if ({done, wb_en, busy, mem_req, wb_data} !== {4'b0000, exp_wb}) begin
      errors++;
      $display("FAIL idle_after: got done/wb_en/busy/req/wb_data=%b%b%b%b/%h expected 0000/%h",
               done, wb_en, busy, mem_req, wb_data, exp_wb);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; is_store = 1'b1; addr = 8'($urandom); wdata = 8'($urandom);
    mem_ack = 1'b1; mem_rdata = 8'($urandom);
    #1;
    checks++;
    if ({busy, done, wb_en, mem_req, mem_we, err, mem_addr, mem_wdata, wb_data} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {busy, done, wb_en, mem_req, mem_we, err, mem_addr, mem_wdata, wb_data});
    end
    start = 1'b0; mem_ack = 1'b0;
    exp_wb = 8'h00;
    @(negedge CLK);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if ({busy, mem_req, done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got busy/req/done=%b%b%b expected 000", i, busy, mem_req, done);
      end
    end
  endtask

  task automatic test_load_zero_wait();
    run_op(1'b0, 8'h3C, 8'($urandom), 0);
  endtask

  task automatic test_store_wait3();
    run_op(1'b1, 8'h10, 8'h7E, 3);
  endtask

  task automatic test_ignored_start();
    start = 1'b1; is_store = 1'b0; addr = 8'h22;
    @(negedge CLK);
    addr = 8'h55; is_store = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h22}) begin
        errors++;
        $display("FAIL ignored_start_req %0d: got req/we/addr=%b%b/%h expected 10/22", i, mem_req, mem_we, mem_addr);
      end
      mem_ack = (i == 2); mem_rdata = (i == 2) ? mem[8'h22] : 8'($urandom);
      @(negedge CLK);
    end
    exp_wb = mem[8'h22];
    mem_ack = 1'b0;
    checks++;
    if ({done, wb_en, wb_data} !== {2'b11, exp_wb}) begin
      errors++;
      $display("FAIL ignored_start_done: got done/wb_en/wb_data=%b%b/%h expected 11/%h", done, wb_en, wb_data, exp_wb);
    end
    @(negedge CLK);
    checks++;
    if ({busy, mem_req, done} !== 3'b000) begin
      errors++;
      $display("FAIL ignored_start_idle: got busy/req/done=%b%b%b expected 000", busy, mem_req, done);
    end
    run_op(1'b0, 8'h66, 8'($urandom), 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++)
      run_op(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic test_timeout();
`ifdef LDST_TIMEOUT_EN
    start = 1'b1; is_store = 1'b0; addr = 8'h40;
    @(negedge CLK);
    start = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_req, err} !== 2'b10) begin
        errors++;
        $display("FAIL timeout_req %0d: got req/err=%b%b expected 10", i, mem_req, err);
      end
      @(negedge CLK);
    end
    checks++;
    if ({done, wb_en, err, mem_req, wb_data} !== {4'b1010, exp_wb}) begin
      errors++;
      $display("FAIL timeout_done: got done/wb_en/err/req/wb_data=%b%b%b%b/%h expected 1010/%h",
               done, wb_en, err, mem_req, wb_data, exp_wb);
    end
    @(negedge CLK);
    run_op(1'b0, 8'h41, 8'($urandom), 1);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got err=%b expected 1", err);
    end
`else
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_tied: got err=%b expected 0", err);
    end
`endif
  endtask

  task automatic test_reset_mid_req();
    start = 1'b1; is_store = 1'b0; addr = 8'h77;
    @(negedge CLK);
    start = 1'b0; mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: got req=%b expected 1", mem_req);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_async: got req/busy=%b%b expected 00", mem_req, busy);
    end
    exp_wb = 8'h00;
    @(negedge CLK);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1; mem_rdata = 8'($urandom);
      @(negedge CLK);
      checks++;
      if ({done, busy, wb_en, err, wb_data} !== 12'h000) begin
        errors++;
        $display("FAIL midreset_after %0d: got done/busy/wb_en/err/wb_data=%b%b%b%b/%h expected 0000/00",
                 i, done, busy, wb_en, err, wb_data);
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h3C] = 8'hA5;
    test_reset();
    test_load_zero_wait();
    test_store_wait3();
    test_ignored_start();
    test_back_to_back();
    test_timeout();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
